// File: rtl/alu_pkg.sv
// Shared types for the tinyALU command driver: opcodes, FSM states and opcode legality.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } drv_state_e;

  // NOP is legal but never reaches the ALU; 101-111 are undefined opcodes.
  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  // Empty clears one cycle after the first write into an empty FIFO but sets
  // immediately on drain, so a reader never sees a word on the edge it lands.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    full_d   = (count_d == (AW+1)'(DEPTH));
    empty_d  = (count_d == '0) || (count_q == '0);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = count_q;

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the tinyALU start/done handshake: queues commands, issues them one
// at a time with a timeout, and returns result or error on a valid/ready port.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  output logic                alu_start,
  output logic [2:0]          alu_op,
  output logic [DATA_W-1:0]   alu_A,
  output logic [DATA_W-1:0]   alu_B,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic                rsp_err,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int CMD_W = OP_W + 2*DATA_W;
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int LVL_W = $clog2(CMD_DEPTH) + 1;

  // Valid/ready: a transfer happens on a rising edge where both are 1; the
  // source holds payload stable while valid is high and ready is low.

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0]  fifo_wdata, fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic [OP_W-1:0]   head_op;
  logic [DATA_W-1:0] head_a, head_b;

  drv_state_e          state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                alu_start_q, alu_start_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2*DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic                rsp_err_q, rsp_err_d;

  assign fifo_push  = cmd_valid && !fifo_full;
  assign fifo_wdata = {cmd_op, cmd_a, cmd_b};
  assign {head_op, head_a, head_b} = fifo_rdata;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (fifo_wdata),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    alu_start_d  = alu_start_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_op == OP_NOP || !is_legal_op(head_op)) begin
            // Answered locally; the ALU never sees these.
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_err_d    = (head_op != OP_NOP);
            state_d      = ST_RESP;
          end else begin
            alu_start_d = 1'b1;
            alu_op_d    = head_op;
            alu_a_d     = head_a;
            alu_b_d     = head_b;
            tmr_d       = '0;
            state_d     = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (alu_done) begin
          alu_start_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          alu_start_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      alu_start_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      alu_start_q  <= alu_start_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign cmd_ready  = !fifo_full;
  assign alu_start  = alu_start_q;
  assign alu_op     = alu_op_q;
  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != ST_IDLE) || (fifo_level != '0);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: model ALU with per-command latency, response scoreboard,
// directed scenarios followed by a randomized run.
module tb_alu_cmd_driver;

  localparam int DW  = 32;
  localparam int RW  = 2*DW + 1;
  localparam int CW  = 72;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_a, cmd_b;
  logic          alu_start;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_A, alu_B;
  logic          alu_done;
  logic [2*DW-1:0] alu_result;
  logic          rsp_valid, rsp_ready;
  logic [2*DW-1:0] rsp_result;
  logic          rsp_err, busy;
  logic [1:0]    dbg_state;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            lat;
  } issue_t;

  logic [RW-1:0] exp_q[$];
  issue_t        issue_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cyc, rise_cyc, last_hold, start_rises, stray_cyc;
  int rr_mode;
  logic rr_bit;

  always #5 clk = ~clk;

  assign rsp_ready = (rr_mode == 1) || (rr_mode == 2 && rr_bit);

  alu_cmd_driver #(.DATA_W(DW), .CMD_DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Reference behaviour of a command, computed from the opcode table.
  function automatic logic [2*DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    logic [2*DW-1:0] wa, wb;
    wa = {{DW{1'b0}}, a};
    wb = {{DW{1'b0}}, b};
    case (op)
      3'd1:    return wa + wb;
      3'd2:    return wa & wb;
      3'd3:    return wa ^ wb;
      3'd4:    return wa * wb;
      default: return '0;
    endcase
  endfunction

  function automatic logic [RW-1:0] exp_rsp(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input int lat);
    if (op == 3'd0) return '0;
    if (op > 3'd4) return {1'b1, {2*DW{1'b0}}};
    if (lat == 0 || lat > TMO) return {1'b1, {2*DW{1'b0}}};
    return {1'b0, alu_fn(op, a, b)};
  endfunction

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    rr_bit = 1'b0;
    forever begin
      @(posedge clk); #1;
      rr_bit = ($urandom_range(0, 3) != 0);
    end
  end

  // Model ALU: raises done in the lat-th cycle of start (lat 0 = never answers).
  initial begin
    int hold, cur_lat;
    issue_t cur;
    hold = 0; cur_lat = 0; start_rises = 0; last_hold = 0; rise_cyc = 0;
    alu_done = 1'b0; alu_result = '0;
    forever begin
      @(posedge clk); #1;
      alu_done = 1'b0;
      if (reset_n && alu_start) begin
        if (hold == 0) begin
          start_rises++;
          rise_cyc = cyc;
          if (issue_q.size() == 0) begin
            check("alu_spurious_start", CW'(issue_q.size()), CW'(1));
            cur = '{op: alu_op, a: alu_A, b: alu_B, lat: 1};
          end else begin
            cur = issue_q.pop_front();
            check("alu_issue", CW'({alu_op, alu_A, alu_B}), CW'({cur.op, cur.a, cur.b}));
          end
          cur_lat = cur.lat;
        end else begin
          check("alu_stable", CW'({alu_op, alu_A, alu_B}), CW'({cur.op, cur.a, cur.b}));
        end
        hold++;
        if (hold == cur_lat) begin
          alu_done   = 1'b1;
          alu_result = alu_fn(alu_op, alu_A, alu_B);
        end
      end else begin
        if (hold != 0) last_hold = hold;
        hold = 0;
        if (cyc == stray_cyc) begin
          alu_done   = 1'b1;
          alu_result = {$urandom, $urandom};
        end
      end
    end
  end

  // Scoreboard: every response handshake is compared with the oldest expected entry.
  initial begin
    logic [RW-1:0] held, want;
    logic held_v;
    held_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset_n && rsp_valid) begin
        if (held_v) check("rsp_stable", CW'({rsp_err, rsp_result}), CW'(held));
        if (rsp_ready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", CW'(exp_q.size()), CW'(1));
          end else begin
            want = exp_q.pop_front();
            check("rsp", CW'({rsp_err, rsp_result}), CW'(want));
          end
        end else begin
          held_v = 1'b1;
          held   = {rsp_err, rsp_result};
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int lat);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_accept", CW'(cmd_ready), CW'(1));
    if (cmd_ready) begin
      hs_cyc = cyc + 1;
      exp_q.push_back(exp_rsp(op, a, b, lat));
      if (op >= 3'd1 && op <= 3'd4) issue_q.push_back('{op: op, a: a, b: b, lat: lat});
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_pending", CW'(exp_q.size()), CW'(0));
    check("idle_busy", CW'(busy), CW'(0));
  endtask

  task automatic wait_start(input logic val);
    int n;
    n = 0;
    while (alu_start !== val && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_start", CW'(alu_start), CW'(val));
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_rsp", CW'(rsp_valid), CW'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [2:0] op;
    int r, lat;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    rr_mode = 0; stray_cyc = -1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", CW'(cmd_ready), CW'(1));
    check("rst_alu_start", CW'(alu_start), CW'(0));
    check("rst_alu_opab", CW'({alu_op, alu_A, alu_B}), CW'(0));
    check("rst_rsp_valid", CW'(rsp_valid), CW'(0));
    check("rst_rsp_data", CW'({rsp_err, rsp_result}), CW'(0));
    check("rst_busy", CW'(busy), CW'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    rr_mode = 1;

    // ADD 5+7, single-cycle ALU
    send_cmd(3'd1, 32'd5, 32'd7, 1);
    wait_idle();
    check("t1_start_latency", CW'(rise_cyc - hs_cyc), CW'(2));
    check("t1_start_hold", CW'(last_hold), CW'(1));

    // MUL 3*4 with 3-cycle ALU, response held back
    rr_mode = 0;
    s0 = start_rises;
    send_cmd(3'd4, 32'd3, 32'd4, 3);
    send_cmd(3'd1, 32'd1, 32'd1, 1);
    wait_rsp();
    repeat (6) @(posedge clk);
    #1;
    check("t2_one_start", CW'(start_rises - s0), CW'(1));
    check("t2_start_hold", CW'(last_hold), CW'(3));
    check("t2_start_low", CW'(alu_start), CW'(0));
    check("t2_result", CW'({rsp_valid, rsp_err, rsp_result}), CW'({2'b10, 64'd12}));
    rr_mode = 1;
    wait_idle();
    check("t2_two_starts", CW'(start_rises - s0), CW'(2));

    // Illegal opcode then NOP never reach the ALU
    s0 = start_rises;
    send_cmd(3'b110, $urandom, $urandom, 1);
    send_cmd(3'b000, $urandom, $urandom, 1);
    wait_idle();
    check("t3_no_start", CW'(start_rises - s0), CW'(0));

    // Timeout, then a stray done two cycles after start drops
    s0 = start_rises;
    send_cmd(3'd1, 32'd1, 32'd2, 0);
    wait_start(1'b1);
    wait_start(1'b0);
    #1;
    check("t4_timeout_hold", CW'(last_hold), CW'(TMO));
    stray_cyc = cyc + 2;
    repeat (5) @(posedge clk);
    #1;
    check("t4_stray_busy", CW'(busy), CW'(0));
    check("t4_stray_rsp", CW'(rsp_valid), CW'(0));
    check("t4_stray_start", CW'(start_rises - s0), CW'(1));
    wait_idle();

    // Done in the last allowed cycle wins; one cycle later is a timeout
    send_cmd(3'd3, $urandom, $urandom, TMO);
    wait_idle();
    check("t4_done_at_limit", CW'(last_hold), CW'(TMO));
    send_cmd(3'd2, $urandom, $urandom, TMO + 1);
    wait_idle();
    check("t4_past_limit", CW'(last_hold), CW'(TMO));

    // Back-pressure: five commands, FIFO fills at four held
    rr_mode = 0;
    for (int i = 0; i < 5; i++) begin
      send_cmd(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(1, 2));
      if (i == 3) check("t5_ready_at_3", CW'(cmd_ready), CW'(1));
      if (i == 4) check("t5_full_at_4", CW'(cmd_ready), CW'(0));
    end
    check("t5_busy", CW'(busy), CW'(1));
    rr_mode = 1;
    wait_idle();

    // Reset in the second cycle of a 3-cycle MUL
    send_cmd(3'd4, $urandom, $urandom, 3);
    wait_start(1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t6_start", CW'(alu_start), CW'(0));
    check("t6_rsp_valid", CW'(rsp_valid), CW'(0));
    check("t6_busy", CW'(busy), CW'(0));
    check("t6_cmd_ready", CW'(cmd_ready), CW'(1));
    exp_q.delete();
    issue_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Randomized run with random response back-pressure
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      lat = (r == 0) ? 0 : (r == 1) ? TMO : $urandom_range(1, 4);
      send_cmd(op, $urandom, $urandom, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rr_mode = 1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
